// File: rtl/trace_pkg.sv
// Shared state encoding, entry layout and width derivations for the dmem trace buffer.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ch_w(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int entry_w(input int num_ch, input int pc_w, input int addr_w, input int data_w);
        return ch_w(num_ch) + pc_w + addr_w + data_w;
    endfunction

    // Entry layout is {ch, pc, addr, data}; data sits at bit 0.
    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int pc_lsb(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

    function automatic int ch_lsb(input int data_w, input int addr_w, input int pc_w);
        return data_w + addr_w + pc_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one write port and one registered read port that returns
// zero when the read is not enabled; a same-slot read/write returns old data.
module trace_ram #(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 57,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   raddr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [ENTRY_W-1:0] rd_data_r;

    // Storage array write port (contents deliberately not reset).
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; cleared when no valid read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[raddr];
        end else begin
            rd_data_r <= '0;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/dmem_trace_buffer.sv
// Trace capture unit: arbitrates write events from several sources into a
// circular buffer under an arm/trigger/post-count FSM, with indexed readout.
module dmem_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int PC_W    = 12,
    parameter int DEPTH   = 16,
    parameter int NUM_CH  = 2,
    localparam int IDX_W   = idx_w(DEPTH),
    localparam int CNT_W   = cnt_w(DEPTH),
    localparam int CH_W    = ch_w(NUM_CH),
    localparam int ENTRY_W = entry_w(NUM_CH, PC_W, ADDR_W, DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic                     mode_wrap,
    input  logic                     trig_en,
    input  logic [ADDR_W-1:0]        trig_addr,
    input  logic [CNT_W-1:0]         post_count,
    input  logic [NUM_CH-1:0]        ev_valid,
    input  logic [NUM_CH*PC_W-1:0]   ev_pc,
    input  logic [NUM_CH*ADDR_W-1:0] ev_addr,
    input  logic [NUM_CH*DATA_W-1:0] ev_data,
    input  logic                     rd_req,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [ENTRY_W-1:0]       rd_entry,
    output logic                     rd_valid,
    output logic [1:0]               state,
    output logic [CNT_W-1:0]         count,
    output logic                     triggered,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    trace_state_e       state_r, state_nx_s;
    logic [IDX_W-1:0]   wr_ptr_r, wr_ptr_nx_s;
    logic [CNT_W-1:0]   count_r, count_nx_s;
    logic [CNT_W-1:0]   rem_r, rem_nx_s, rem_init_s;
    logic               triggered_r, trig_nx_s;
    logic               overflow_r, ovf_nx_s;
    logic [7:0]         drop_r, drop_nx_s, drop_sat_s;
    logic [8:0]         drop_sum_s;

    logic               win_valid_s;
    logic [CH_W-1:0]    win_ch_s;
    logic [CH_W:0]      vld_cnt_s, drop_inc_s;
    logic [PC_W-1:0]    win_pc_s;
    logic [ADDR_W-1:0]  win_addr_s;
    logic [DATA_W-1:0]  win_data_s;
    logic [ENTRY_W-1:0] wr_entry_s;
    logic               full_s, trig_hit_s, we_s;

    logic [IDX_W-1:0]   rd_phys_s;
    logic               rd_ok_s, rd_valid_r;

    // Lowest-index valid channel wins; count all valid channels for drop accounting.
    always_comb begin
        win_ch_s  = '0;
        vld_cnt_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            win_ch_s  = ev_valid[i] ? CH_W'(i) : win_ch_s;
            vld_cnt_s = vld_cnt_s + {{CH_W{1'b0}}, ev_valid[i]};
        end
    end

    assign win_valid_s = |ev_valid;
    assign drop_inc_s  = win_valid_s ? (vld_cnt_s - {{CH_W{1'b0}}, 1'b1}) : '0;
    assign drop_sum_s  = {1'b0, drop_r} + 9'(drop_inc_s);
    assign drop_sat_s  = drop_sum_s[8] ? 8'd255 : drop_sum_s[7:0];

    assign win_pc_s   = ev_pc[int'(win_ch_s) * PC_W +: PC_W];
    assign win_addr_s = ev_addr[int'(win_ch_s) * ADDR_W +: ADDR_W];
    assign win_data_s = ev_data[int'(win_ch_s) * DATA_W +: DATA_W];
    assign wr_entry_s = {win_ch_s, win_pc_s, win_addr_s, win_data_s};

    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign trig_hit_s = !trig_en || (win_addr_s == trig_addr);
    // Clamp keeps the trigger entry from being overwritten by post-trigger events.
    assign rem_init_s = (post_count > CNT_W'(DEPTH - 1)) ? CNT_W'(DEPTH - 1) : post_count;

    // Next-state and capture decisions for the arm/trigger/post FSM.
    always_comb begin
        state_nx_s  = state_r;
        wr_ptr_nx_s = wr_ptr_r;
        count_nx_s  = count_r;
        rem_nx_s    = rem_r;
        trig_nx_s   = triggered_r;
        ovf_nx_s    = overflow_r;
        drop_nx_s   = drop_r;
        we_s        = 1'b0;
        if (arm) begin
            state_nx_s  = ST_ARMED;
            wr_ptr_nx_s = '0;
            count_nx_s  = '0;
            rem_nx_s    = '0;
            trig_nx_s   = 1'b0;
            ovf_nx_s    = 1'b0;
            drop_nx_s   = 8'd0;
        end else begin
            case (state_r)
                ST_ARMED, ST_POST: begin
                    if (win_valid_s) begin
                        drop_nx_s = drop_sat_s;
                        if ((state_r == ST_ARMED) && full_s && !mode_wrap) begin
                            ovf_nx_s   = 1'b1;
                            state_nx_s = ST_DONE;
                        end else begin
                            we_s        = 1'b1;
                            wr_ptr_nx_s = wr_ptr_r + IDX_W'(1);
                            if (full_s) begin
                                ovf_nx_s = 1'b1;
                            end else begin
                                count_nx_s = count_r + CNT_W'(1);
                            end
                            if (state_r == ST_ARMED) begin
                                if (trig_hit_s) begin
                                    trig_nx_s = 1'b1;
                                    if (post_count == '0) begin
                                        state_nx_s = ST_DONE;
                                    end else begin
                                        state_nx_s = ST_POST;
                                        rem_nx_s   = rem_init_s;
                                    end
                                end else begin
                                    state_nx_s = ST_ARMED;
                                end
                            end else begin
                                rem_nx_s = rem_r - CNT_W'(1);
                                if (rem_r == CNT_W'(1)) begin
                                    state_nx_s = ST_DONE;
                                end else begin
                                    state_nx_s = ST_POST;
                                end
                            end
                        end
                    end else begin
                        drop_nx_s = drop_r;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    state_nx_s = state_r;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // Capture state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            rem_r       <= '0;
            triggered_r <= 1'b0;
            overflow_r  <= 1'b0;
            drop_r      <= 8'd0;
        end else begin
            state_r     <= state_nx_s;
            wr_ptr_r    <= wr_ptr_nx_s;
            count_r     <= count_nx_s;
            rem_r       <= rem_nx_s;
            triggered_r <= trig_nx_s;
            overflow_r  <= ovf_nx_s;
            drop_r      <= drop_nx_s;
        end
    end

    // Logical index 0 is the oldest stored entry.
    assign rd_phys_s = wr_ptr_r - count_r[IDX_W-1:0] + rd_idx;
    assign rd_ok_s   = rd_req && (CNT_W'(rd_idx) < count_r);

    // Read-valid flag aligned with the registered RAM output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_ok_s;
        end
    end

    trace_ram #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we_s),
        .waddr   (wr_ptr_r),
        .wdata   (wr_entry_s),
        .rd_en   (rd_ok_s),
        .raddr   (rd_phys_s),
        .rd_data (rd_entry)
    );

    assign rd_valid  = rd_valid_r;
    assign state     = state_r;
    assign count     = count_r;
    assign triggered = triggered_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_r;

endmodule

// File: tb/tb_dmem_trace_buffer.sv
// Self-checking bench for dmem_trace_buffer: a queue-based reference model of
// the capture rules plus a read scoreboard checked when rd_valid is due.
module tb_dmem_trace_buffer;
    import trace_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 12;
    localparam int PC_W    = 12;
    localparam int DEPTH   = 16;
    localparam int NUM_CH  = 2;
    localparam int IDX_W   = idx_w(DEPTH);
    localparam int CNT_W   = cnt_w(DEPTH);
    localparam int ENTRY_W = entry_w(NUM_CH, PC_W, ADDR_W, DATA_W);

    typedef struct packed {
        logic               vld;
        logic [ENTRY_W-1:0] ent;
    } rd_exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     arm = 1'b0;
    logic                     mode_wrap = 1'b0;
    logic                     trig_en = 1'b0;
    logic [ADDR_W-1:0]        trig_addr = '0;
    logic [CNT_W-1:0]         post_count = '0;
    logic [NUM_CH-1:0]        ev_valid = '0;
    logic [NUM_CH*PC_W-1:0]   ev_pc = '0;
    logic [NUM_CH*ADDR_W-1:0] ev_addr = '0;
    logic [NUM_CH*DATA_W-1:0] ev_data = '0;
    logic                     rd_req = 1'b0;
    logic [IDX_W-1:0]         rd_idx = '0;
    logic [ENTRY_W-1:0]       rd_entry;
    logic                     rd_valid;
    logic [1:0]               state;
    logic [CNT_W-1:0]         count;
    logic                     triggered;
    logic                     overflow;
    logic [7:0]               drop_cnt;

    dmem_trace_buffer #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .PC_W (PC_W), .DEPTH (DEPTH), .NUM_CH (NUM_CH)
    ) dut (
        .clk (clk), .rst_n (rst_n), .arm (arm), .mode_wrap (mode_wrap), .trig_en (trig_en),
        .trig_addr (trig_addr), .post_count (post_count), .ev_valid (ev_valid), .ev_pc (ev_pc),
        .ev_addr (ev_addr), .ev_data (ev_data), .rd_req (rd_req), .rd_idx (rd_idx),
        .rd_entry (rd_entry), .rd_valid (rd_valid), .state (state), .count (count),
        .triggered (triggered), .overflow (overflow), .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    rd_exp_t sb_q[$];
    rd_exp_t sb_e;
    logic    rd_pend = 1'b0;

    int                 m_state;
    logic [ENTRY_W-1:0] m_q[$];
    logic               m_trig, m_ovf;
    int                 m_drop, m_rem;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic m_reset();
        m_state = 0; m_q.delete(); m_trig = 1'b0; m_ovf = 1'b0; m_drop = 0; m_rem = 0;
    endtask

    task automatic m_arm();
        m_reset();
        m_state = 1;
    endtask

    // Reference capture rules for one cycle of events.
    task automatic m_capture(input logic [NUM_CH-1:0] v, input logic [ENTRY_W-1:0] e0,
                             input logic [ENTRY_W-1:0] e1);
        logic [ENTRY_W-1:0] w;
        logic [ADDR_W-1:0]  a;
        if (v == '0 || !(m_state == 1 || m_state == 2)) return;
        m_drop = m_drop + $countones(v) - 1;
        if (m_drop > 255) m_drop = 255;
        w = v[0] ? e0 : e1;
        a = w[addr_lsb(DATA_W) +: ADDR_W];
        if (m_state == 1 && m_q.size() == DEPTH && !mode_wrap) begin
            m_ovf = 1'b1;
            m_state = 3;
            return;
        end
        m_q.push_back(w);
        if (m_q.size() > DEPTH) begin
            void'(m_q.pop_front());
            m_ovf = 1'b1;
        end
        if (m_state == 1) begin
            if (!trig_en || a == trig_addr) begin
                m_trig = 1'b1;
                if (post_count == '0) m_state = 3;
                else begin
                    m_state = 2;
                    m_rem = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
                end
            end
        end else begin
            m_rem--;
            if (m_rem == 0) m_state = 3;
        end
    endtask

    task automatic send(input logic a, input logic [NUM_CH-1:0] v,
                        input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        logic [DATA_W-1:0] d0, d1;
        logic [PC_W-1:0]   p0, p1;
        d0 = $urandom; d1 = $urandom;
        p0 = a0 ^ 12'h5A5; p1 = a1 + 12'h321;
        arm = a; ev_valid = v; ev_addr = {a1, a0}; ev_pc = {p1, p0}; ev_data = {d1, d0};
        if (a) m_arm();
        else m_capture(v, {1'b0, p0, a0, d0}, {1'b1, p1, a1, d1});
        step();
        arm = 1'b0; ev_valid = '0;
    endtask

    task automatic rd(input int idx);
        rd_exp_t e;
        if (idx < m_q.size()) begin
            e.vld = 1'b1; e.ent = m_q[idx];
        end else begin
            e.vld = 1'b0; e.ent = '0;
        end
        sb_q.push_back(e);
        rd_req = 1'b1; rd_idx = IDX_W'(idx);
        step();
        rd_req = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check_val({tag, "_state"}, state, m_state);
        check_val({tag, "_count"}, count, m_q.size());
        check_val({tag, "_trig"}, triggered, m_trig);
        check_val({tag, "_ovf"}, overflow, m_ovf);
        check_val({tag, "_drop"}, drop_cnt, m_drop);
    endtask

    // Read results arrive one cycle after the request edge.
    always @(posedge clk) rd_pend <= rd_req;

    // Scoreboard pop and compare on the falling edge.
    always @(negedge clk) begin
        if (rd_pend) begin
            check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                sb_e = sb_q.pop_front();
                check_val("rd_valid", rd_valid, sb_e.vld);
                check_val("rd_entry", rd_entry, sb_e.ent);
            end
        end else begin
            check_val("rd_idle", rd_valid, 1'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_reset();
        repeat (3) step();
        check_val("rst_state", state, 2'd0);
        check_val("rst_count", count, 5'd0);
        check_val("rst_trig", triggered, 1'b0);
        check_val("rst_ovf", overflow, 1'b0);
        check_val("rst_drop", drop_cnt, 8'd0);
        check_val("rst_rd_entry", rd_entry, '0);
        rst_n = 1'b1;
        step();

        // Events before any arm are ignored.
        send(1'b0, 2'b01, 12'd7, 12'd0);
        check_status("idle");
        rd(0);

        // Basic capture: first event triggers, three post events.
        mode_wrap = 1'b0; trig_en = 1'b0; post_count = 5'd3; trig_addr = 12'd0;
        send(1'b1, 2'b00, 12'd0, 12'd0);
        for (int i = 1; i <= 4; i++) begin
            send(1'b0, 2'b01, ADDR_W'(i), 12'd0);
            if (i == 3) check_val("basic_post", state, 2'd2);
        end
        check_val("basic_state", state, 2'd3);
        check_val("basic_count", count, 5'd4);
        check_val("basic_trig", triggered, 1'b1);
        check_status("basic");
        for (int i = 0; i < 6; i++) rd(i);
        send(1'b0, 2'b01, 12'd9, 12'd0);
        check_val("done_hold", count, 5'd4);

        // Wrap mode with a late address trigger.
        mode_wrap = 1'b1; trig_en = 1'b1; trig_addr = 12'd100; post_count = 5'd2;
        send(1'b1, 2'b00, 12'd0, 12'd0);
        for (int i = 0; i < 20; i++) send(1'b0, 2'b01, ADDR_W'(i), 12'd0);
        check_val("wrap_armed", state, 2'd1);
        check_val("wrap_ovf", overflow, 1'b1);
        send(1'b0, 2'b01, 12'd100, 12'd0);
        check_val("wrap_post", state, 2'd2);
        send(1'b0, 2'b01, 12'd200, 12'd0);
        send(1'b0, 2'b01, 12'd201, 12'd0);
        check_val("wrap_done", state, 2'd3);
        check_val("wrap_count", count, 5'd16);
        check_status("wrap");
        for (int i = 0; i < DEPTH; i++) rd(i);

        // Stop when full.
        mode_wrap = 1'b0; trig_en = 1'b1; trig_addr = 12'hFFF; post_count = 5'd2;
        send(1'b1, 2'b00, 12'd0, 12'd0);
        for (int i = 0; i < 16; i++) send(1'b0, 2'b01, ADDR_W'(i), 12'd0);
        check_val("full_armed", state, 2'd1);
        check_val("full_noovf", overflow, 1'b0);
        send(1'b0, 2'b01, 12'd16, 12'd0);
        check_val("full_done", state, 2'd3);
        check_val("full_count", count, 5'd16);
        check_val("full_ovf", overflow, 1'b1);
        check_status("full");
        for (int i = 0; i < DEPTH; i++) rd(i);

        // Channel collisions.
        send(1'b1, 2'b00, 12'd0, 12'd0);
        for (int i = 0; i < 3; i++) send(1'b0, 2'b11, ADDR_W'(i + 1), ADDR_W'(i + 50));
        check_val("coll_count", count, 5'd3);
        check_val("coll_drop", drop_cnt, 8'd3);
        send(1'b0, 2'b10, 12'd0, 12'd77);
        check_status("coll");
        for (int i = 0; i < 5; i++) rd(i);

        // Drop counter saturation.
        mode_wrap = 1'b1;
        send(1'b1, 2'b00, 12'd0, 12'd0);
        for (int i = 0; i < 260; i++) send(1'b0, 2'b11, ADDR_W'(i), ADDR_W'(i + 1));
        check_val("drop_sat", drop_cnt, 8'd255);
        check_status("dsat");

        // Arm beats a coincident event; post_count clamps to DEPTH-1.
        trig_en = 1'b0; post_count = 5'd20;
        send(1'b1, 2'b01, 12'd5, 12'd0);
        check_val("armev_count", count, 5'd0);
        check_val("armev_state", state, 2'd1);
        for (int i = 0; i < 15; i++) send(1'b0, 2'b01, ADDR_W'(i + 30), 12'd0);
        check_val("clamp_post", state, 2'd2);
        send(1'b0, 2'b01, 12'd45, 12'd0);
        check_val("clamp_done", state, 2'd3);
        check_val("clamp_count", count, 5'd16);
        check_status("clamp");
        rd(0);
        rd(15);

        // Asynchronous reset during POST.
        post_count = 5'd5;
        send(1'b1, 2'b00, 12'd0, 12'd0);
        send(1'b0, 2'b01, 12'd1, 12'd0);
        send(1'b0, 2'b01, 12'd2, 12'd0);
        check_val("rst_mid_post", state, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_state", state, 2'd0);
        check_val("arst_count", count, 5'd0);
        check_val("arst_trig", triggered, 1'b0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send(1'b0, 2'b01, 12'd3, 12'd0);
        send(1'b0, 2'b01, 12'd4, 12'd0);
        check_status("post_rst");

        step();
        step();
        check_val("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
